// File: rtl/rv32i_multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, traps illegal
// opcodes and data-bus timeouts, and counts retired instructions.
module rv32i_multicycle_control_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int INSTRET_W      = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instrCode,
    input  logic                 busReady,
    output logic                 irEn,
    output logic                 pcEn,
    output logic                 regFileWe,
    output logic [3:0]           aluControl,
    output logic                 aluSrcMuxSel,
    output logic                 busReq,
    output logic                 busWe,
    output logic [2:0]           RFWDSrcMuxSel,
    output logic                 branch,
    output logic                 jal,
    output logic                 jalr,
    output logic                 illegal,
    output logic                 busTimeout,
    output logic [INSTRET_W-1:0] instret
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

    state_t        state, state_next;
    logic [CW-1:0] wait_cnt, wait_cnt_next;
    logic          set_illegal, set_timeout;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_r, is_i, is_l, is_s, is_b, is_lu, is_au, is_j, is_jl, is_legal;

    assign opcode   = instrCode[6:0];
    assign funct3   = instrCode[14:12];
    assign is_r     = (opcode == 7'b0110011);
    assign is_i     = (opcode == 7'b0010011);
    assign is_l     = (opcode == 7'b0000011);
    assign is_s     = (opcode == 7'b0100011);
    assign is_b     = (opcode == 7'b1100011);
    assign is_lu    = (opcode == 7'b0110111);
    assign is_au    = (opcode == 7'b0010111);
    assign is_j     = (opcode == 7'b1101111);
    assign is_jl    = (opcode == 7'b1100111);
    assign is_legal = is_r | is_i | is_l | is_s | is_b | is_lu | is_au | is_j | is_jl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            wait_cnt   <= '0;
            illegal    <= 1'b0;
            busTimeout <= 1'b0;
            instret    <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (set_illegal) illegal    <= 1'b1;
            if (set_timeout) busTimeout <= 1'b1;
            if (pcEn)        instret    <= instret + INSTRET_W'(1);
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        set_illegal   = 1'b0;
        set_timeout   = 1'b0;
        irEn          = 1'b0;
        pcEn          = 1'b0;
        regFileWe     = 1'b0;
        busReq        = 1'b0;
        busWe         = 1'b0;
        branch        = 1'b0;
        jal           = 1'b0;
        jalr          = 1'b0;
        aluControl    = 4'b0000;
        aluSrcMuxSel  = 1'b0;
        RFWDSrcMuxSel = 3'b000;

        case (state)
            FETCH: begin
                irEn       = 1'b1;
                state_next = DECODE;
            end
            DECODE: begin
                if (!is_legal) begin
                    state_next  = TRAP;
                    set_illegal = 1'b1;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (is_s || is_l) begin
                    state_next = MEM;
                end else if (is_b) begin
                    branch     = 1'b1;
                    pcEn       = 1'b1;
                    state_next = FETCH;
                end else begin
                    regFileWe  = 1'b1;
                    pcEn       = 1'b1;
                    jal        = is_j | is_jl;
                    jalr       = is_jl;
                    state_next = FETCH;
                end
            end
            MEM: begin
                busReq = 1'b1;
                busWe  = is_s;
                // A ready on the last allowed cycle is checked first so it beats the timeout.
                if (busReady) begin
                    wait_cnt_next = '0;
                    pcEn          = is_s;
                    state_next    = is_s ? FETCH : WB;
                end else if (wait_cnt == LAST_WAIT) begin
                    wait_cnt_next = '0;
                    set_timeout   = 1'b1;
                    state_next    = TRAP;
                end else begin
                    wait_cnt_next = wait_cnt + CW'(1);
                end
            end
            WB: begin
                regFileWe  = 1'b1;
                pcEn       = 1'b1;
                state_next = FETCH;
            end
            default: ;
        endcase

        if (state inside {DECODE, EXEC, MEM, WB}) begin
            aluSrcMuxSel = is_i | is_l | is_s;
            if (is_r || is_b)
                aluControl = {instrCode[30], funct3};
            else if (is_i)
                aluControl = ({instrCode[30], funct3} == 4'b1101) ? 4'b1101 : {1'b0, funct3};
            if (is_l)
                RFWDSrcMuxSel = 3'b001;
            else if (is_lu)
                RFWDSrcMuxSel = 3'b010;
            else if (is_au)
                RFWDSrcMuxSel = 3'b011;
            else if (is_j || is_jl)
                RFWDSrcMuxSel = 3'b100;
        end

        // While reset is held nothing may be enabled or requested, whatever state we were in.
        if (reset) begin
            irEn          = 1'b0;
            pcEn          = 1'b0;
            regFileWe     = 1'b0;
            busReq        = 1'b0;
            busWe         = 1'b0;
            branch        = 1'b0;
            jal           = 1'b0;
            jalr          = 1'b0;
            aluControl    = 4'b0000;
            aluSrcMuxSel  = 1'b0;
            RFWDSrcMuxSel = 3'b000;
            set_illegal   = 1'b0;
            set_timeout   = 1'b0;
        end
    end

endmodule

// File: tb/tb_rv32i_multicycle_control_unit.sv
// Directed testbench for rv32i_multicycle_control_unit; a second instance with a
// 2-bit retire counter exercises counter wrap-around.
module tb_rv32i_multicycle_control_unit;

    localparam logic [31:0] ADD   = 32'h002081B3;
    localparam logic [31:0] SUB   = 32'h402081B3;
    localparam logic [31:0] SW    = 32'h0020A023;
    localparam logic [31:0] LW    = 32'h0000A083;
    localparam logic [31:0] JAL   = 32'h008000EF;
    localparam logic [31:0] JALR  = 32'h000080E7;
    localparam logic [31:0] BEQ   = 32'h00208463;
    localparam logic [31:0] LUI   = 32'h123450B7;
    localparam logic [31:0] AUIPC = 32'h00001097;
    localparam logic [31:0] SRAI  = 32'h4030D093;
    localparam logic [31:0] ADDI  = 32'h40008093;
    localparam logic [31:0] ILL   = 32'h0000007F;

    // ctl = {irEn,pcEn,regFileWe,busReq,busWe,branch,jal,jalr}
    localparam logic [7:0] C_NONE = 8'h00;
    localparam logic [7:0] C_IR   = 8'h80;
    localparam logic [7:0] C_RET  = 8'h60;
    localparam logic [7:0] C_BR   = 8'h44;
    localparam logic [7:0] C_JAL  = 8'h62;
    localparam logic [7:0] C_JALR = 8'h63;
    localparam logic [7:0] C_MEMS = 8'h18;
    localparam logic [7:0] C_SRET = 8'h58;
    localparam logic [7:0] C_MEML = 8'h10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instrCode = 32'h0;
    logic        busReady = 1'b0;

    logic        irEn, pcEn, regFileWe, aluSrcMuxSel, busReq, busWe;
    logic        branch, jal, jalr, illegal, busTimeout;
    logic [3:0]  aluControl;
    logic [2:0]  RFWDSrcMuxSel;
    logic [31:0] instret;

    logic        s_irEn, s_pcEn, s_regFileWe, s_aluSrcMuxSel, s_busReq, s_busWe;
    logic        s_branch, s_jal, s_jalr, s_illegal, s_busTimeout;
    logic [3:0]  s_aluControl;
    logic [2:0]  s_RFWDSrcMuxSel;
    logic [1:0]  s_instret;

    logic [7:0]  ctl;
    int          total = 0;
    int          bad = 0;

    assign ctl = {irEn, pcEn, regFileWe, busReq, busWe, branch, jal, jalr};

    rv32i_multicycle_control_unit #(.TIMEOUT_CYCLES(16), .INSTRET_W(32)) dut (
        .clk(clk), .reset(reset), .instrCode(instrCode), .busReady(busReady),
        .irEn(irEn), .pcEn(pcEn), .regFileWe(regFileWe), .aluControl(aluControl),
        .aluSrcMuxSel(aluSrcMuxSel), .busReq(busReq), .busWe(busWe),
        .RFWDSrcMuxSel(RFWDSrcMuxSel), .branch(branch), .jal(jal), .jalr(jalr),
        .illegal(illegal), .busTimeout(busTimeout), .instret(instret)
    );

    rv32i_multicycle_control_unit #(.TIMEOUT_CYCLES(16), .INSTRET_W(2)) dut_small (
        .clk(clk), .reset(reset), .instrCode(instrCode), .busReady(busReady),
        .irEn(s_irEn), .pcEn(s_pcEn), .regFileWe(s_regFileWe), .aluControl(s_aluControl),
        .aluSrcMuxSel(s_aluSrcMuxSel), .busReq(s_busReq), .busWe(s_busWe),
        .RFWDSrcMuxSel(s_RFWDSrcMuxSel), .branch(s_branch), .jal(s_jal), .jalr(s_jalr),
        .illegal(s_illegal), .busTimeout(s_busTimeout), .instret(s_instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs change just after the falling edge, outputs checked 1ns later.
    task automatic step(input logic [31:0] instr, input logic ready);
        @(negedge clk);
        instrCode = instr;
        busReady  = ready;
        #1;
    endtask

    // Hold reset for two cycles, then release so the caller lands in the FETCH cycle.
    task automatic do_reset(input logic [31:0] first_instr);
        reset = 1'b1;
        step(32'h0, 1'b0);
        chk("rst_ctl0", {24'h0, ctl}, {24'h0, C_NONE});
        step(32'h0, 1'b1);
        chk("rst_ctl1", {24'h0, ctl}, {24'h0, C_NONE});
        chk("rst_instret", instret, 32'd0);
        chk("rst_flags", {30'h0, illegal, busTimeout}, 32'd0);
        chk("rst_sel", {25'h0, aluControl, RFWDSrcMuxSel}, 32'd0);
        reset     = 1'b0;
        instrCode = first_instr;
        busReady  = 1'b0;
        #1;
    endtask

    initial begin
        // R-type add straight out of reset
        do_reset(ADD);
        chk("add_c0_ctl", {24'h0, ctl}, {24'h0, C_IR});
        step(ADD, 1'b0);
        chk("add_c1_ctl", {24'h0, ctl}, {24'h0, C_NONE});
        step(ADD, 1'b0);
        chk("add_c2_ctl", {24'h0, ctl}, {24'h0, C_RET});
        chk("add_c2_alu", {28'h0, aluControl}, 32'h0);
        chk("add_c2_rfwd", {29'h0, RFWDSrcMuxSel}, 32'h0);

        // Store with ready on the third MEM cycle; ready outside MEM is ignored
        step(SW, 1'b1);
        chk("sw_fetch_ctl", {24'h0, ctl}, {24'h0, C_IR});
        chk("add_instret", instret, 32'd1);
        step(SW, 1'b1);
        chk("sw_dec_src", {31'h0, aluSrcMuxSel}, 32'd1);
        step(SW, 1'b1);
        chk("sw_exec_ctl", {24'h0, ctl}, {24'h0, C_NONE});
        step(SW, 1'b0);
        chk("sw_mem1_ctl", {24'h0, ctl}, {24'h0, C_MEMS});
        step(SW, 1'b0);
        chk("sw_mem2_ctl", {24'h0, ctl}, {24'h0, C_MEMS});
        step(SW, 1'b1);
        chk("sw_mem3_ctl", {24'h0, ctl}, {24'h0, C_SRET});
        chk("sw_alu", {28'h0, aluControl}, 32'h0);

        // Load with ready on the first MEM cycle
        step(LW, 1'b1);
        chk("sw_instret", instret, 32'd2);
        step(LW, 1'b1);
        step(LW, 1'b1);
        chk("lw_exec_ctl", {24'h0, ctl}, {24'h0, C_NONE});
        step(LW, 1'b1);
        chk("lw_mem_ctl", {24'h0, ctl}, {24'h0, C_MEML});
        step(LW, 1'b0);
        chk("lw_wb_ctl", {24'h0, ctl}, {24'h0, C_RET});
        chk("lw_wb_rfwd", {29'h0, RFWDSrcMuxSel}, 32'h1);
        chk("lw_wb_src", {31'h0, aluSrcMuxSel}, 32'd1);

        // Jumps, branch, upper-immediates; small counter wraps after 4 retires
        step(JAL, 1'b0);
        chk("lw_instret", instret, 32'd3);
        chk("small_instret3", {30'h0, s_instret}, 32'd3);
        step(JAL, 1'b0);
        step(JAL, 1'b0);
        chk("jal_ctl", {24'h0, ctl}, {24'h0, C_JAL});
        chk("jal_rfwd", {29'h0, RFWDSrcMuxSel}, 32'h4);
        step(BEQ, 1'b0);
        chk("small_wrap", {30'h0, s_instret}, 32'd0);
        chk("jal_instret", instret, 32'd4);
        step(BEQ, 1'b0);
        step(BEQ, 1'b0);
        chk("beq_ctl", {24'h0, ctl}, {24'h0, C_BR});
        chk("beq_alu", {28'h0, aluControl}, 32'h0);
        step(JALR, 1'b0);
        step(JALR, 1'b0);
        step(JALR, 1'b0);
        chk("jalr_ctl", {24'h0, ctl}, {24'h0, C_JALR});
        chk("jalr_rfwd", {29'h0, RFWDSrcMuxSel}, 32'h4);
        step(LUI, 1'b0);
        step(LUI, 1'b0);
        step(LUI, 1'b0);
        chk("lui_ctl", {24'h0, ctl}, {24'h0, C_RET});
        chk("lui_rfwd", {29'h0, RFWDSrcMuxSel}, 32'h2);
        step(AUIPC, 1'b0);
        step(AUIPC, 1'b0);
        step(AUIPC, 1'b0);
        chk("auipc_rfwd", {29'h0, RFWDSrcMuxSel}, 32'h3);

        // ALU control corner cases
        step(SRAI, 1'b0);
        chk("srai_fetch_alu", {28'h0, aluControl}, 32'h0);
        step(SRAI, 1'b0);
        chk("srai_dec_alu", {28'h0, aluControl}, 32'hD);
        step(SRAI, 1'b0);
        chk("srai_exec_alu", {28'h0, aluControl}, 32'hD);
        chk("srai_src", {31'h0, aluSrcMuxSel}, 32'd1);
        step(ADDI, 1'b0);
        step(ADDI, 1'b0);
        step(ADDI, 1'b0);
        chk("addi30_alu", {28'h0, aluControl}, 32'h0);
        step(SUB, 1'b0);
        step(SUB, 1'b0);
        step(SUB, 1'b0);
        chk("sub_alu", {28'h0, aluControl}, 32'h8);

        // Load that never gets ready: exactly 16 MEM cycles then TRAP
        step(LW, 1'b0);
        chk("pre_to_instret", instret, 32'd11);
        chk("small_instret11", {30'h0, s_instret}, 32'd3);
        step(LW, 1'b0);
        step(LW, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(LW, 1'b0);
            chk($sformatf("to_mem%0d_ctl", i + 1), {24'h0, ctl}, {24'h0, C_MEML});
        end
        step(LW, 1'b1);
        chk("to_trap_ctl", {24'h0, ctl}, {24'h0, C_NONE});
        chk("to_trap_flags", {30'h0, illegal, busTimeout}, 32'd1);
        step(LW, 1'b1);
        chk("to_sticky", {30'h0, illegal, busTimeout}, 32'd1);
        chk("to_hold_ctl", {24'h0, ctl}, {24'h0, C_NONE});
        chk("to_instret", instret, 32'd11);

        // Ready on the 16th MEM cycle beats the timeout
        do_reset(LW);
        chk("lw2_c0_ctl", {24'h0, ctl}, {24'h0, C_IR});
        step(LW, 1'b0);
        step(LW, 1'b0);
        for (int i = 0; i < 15; i++) begin
            step(LW, 1'b0);
        end
        chk("lw2_mem15_ctl", {24'h0, ctl}, {24'h0, C_MEML});
        step(LW, 1'b1);
        chk("lw2_mem16_ctl", {24'h0, ctl}, {24'h0, C_MEML});
        step(LW, 1'b0);
        chk("lw2_wb_ctl", {24'h0, ctl}, {24'h0, C_RET});
        chk("lw2_no_timeout", {31'h0, busTimeout}, 32'd0);

        // Reset in the middle of a store's MEM cycle
        step(SW, 1'b0);
        chk("lw2_instret", instret, 32'd1);
        step(SW, 1'b0);
        step(SW, 1'b0);
        step(SW, 1'b0);
        chk("mid_mem_ctl", {24'h0, ctl}, {24'h0, C_MEMS});
        reset = 1'b1;
        #1;
        chk("mid_rst_ctl", {24'h0, ctl}, {24'h0, C_NONE});
        step(SW, 1'b1);
        chk("mid_rst_after_ctl", {24'h0, ctl}, {24'h0, C_NONE});
        chk("mid_rst_instret", instret, 32'd0);
        reset     = 1'b0;
        instrCode = ILL;
        busReady  = 1'b0;
        #1;
        chk("mid_rst_fetch", {24'h0, ctl}, {24'h0, C_IR});

        // Illegal opcode traps after DECODE and stays put
        step(ILL, 1'b0);
        chk("ill_dec_ctl", {24'h0, ctl}, {24'h0, C_NONE});
        chk("ill_dec_flag", {31'h0, illegal}, 32'd0);
        step(ILL, 1'b0);
        chk("ill_trap_flag", {31'h0, illegal}, 32'd1);
        chk("ill_trap_ctl", {24'h0, ctl}, {24'h0, C_NONE});
        step(ILL, 1'b1);
        chk("ill_sticky", {30'h0, illegal, busTimeout}, 32'd2);
        step(ADD, 1'b0);
        chk("ill_no_fetch", {24'h0, ctl}, {24'h0, C_NONE});

        do_reset(ADD);
        chk("ill_resume_fetch", {24'h0, ctl}, {24'h0, C_IR});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
